// File: rtl/mux_test_sequencer.sv
// Stimulus/check engine for bench-testing N:1 mux ICs: sweeps the select bus,
// pulses the chip enable, samples dut_y once per code and counts mismatches.
module mux_test_sequencer #(
    parameter int SEL_W         = 3,
    parameter int DWELL         = 4,
    parameter int EN_CYCLES     = 2,
    parameter int GAP_CYCLES    = 28,
    parameter bit EN_ACTIVE_LOW = 1'b0,
    parameter int ERR_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  continuous,
    input  logic [2**SEL_W-1:0]   pattern,
    input  logic                  dut_y,
    output logic                  en_out,
    output logic [SEL_W-1:0]      sel,
    output logic                  strobe,
    output logic                  busy,
    output logic                  done,
    output logic [ERR_W-1:0]      err_cnt,
    output logic                  err
);
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int GP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
    localparam logic [DW_W-1:0] STB_AT  = DW_W'(EN_CYCLES - 1);
    localparam logic [GP_W-1:0] GP_LAST = GP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_SWEEP, S_GAP, S_DONE, S_WAIT_LOW} state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  code_q, code_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [GP_W-1:0]   gap_q, gap_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_q, err_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              en_q, en_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mismatch, sweep_end, act_d;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        dwell_d   = dwell_q;
        gap_d     = gap_q;
        err_cnt_d = err_cnt_q;
        err_d     = err_q;
        sweep_end = 1'b0;

        // strobe_q marks the cycle whose closing edge samples dut_y
        mismatch = strobe_q && (dut_y != pattern[code_q]);
        if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d   = S_SWEEP;
                    code_d    = '0;
                    dwell_d   = '0;
                    err_cnt_d = '0;
                    err_d     = 1'b0;
                end
            end
            S_SWEEP: begin
                if (dwell_q == DW_LAST) begin
                    dwell_d = '0;
                    if (code_q == '1) begin
                        if (GAP_CYCLES > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end else begin
                            sweep_end = 1'b1;
                        end
                    end else begin
                        code_d = code_q + 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GP_LAST) sweep_end = 1'b1;
                else                  gap_d = gap_q + 1'b1;
            end
            S_DONE:     state_d = S_WAIT_LOW;
            S_WAIT_LOW: state_d = S_WAIT_LOW;
            default:    state_d = S_IDLE;
        endcase

        // continuous is taken live at the sweep boundary so it can be changed mid-run
        if (sweep_end) begin
            code_d  = '0;
            dwell_d = '0;
            state_d = continuous ? S_SWEEP : S_DONE;
        end

        if (!enable) begin
            state_d = S_IDLE;
            code_d  = '0;
            dwell_d = '0;
        end

        act_d    = (state_d == S_SWEEP) && (32'(dwell_d) < EN_CYCLES);
        en_d     = act_d ^ EN_ACTIVE_LOW;
        strobe_d = (state_d == S_SWEEP) && (dwell_d == STB_AT);
        sel_d    = (state_d == S_SWEEP) ? code_d : '0;
        busy_d   = (state_d == S_SWEEP) || (state_d == S_GAP);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            code_q    <= '0;
            dwell_q   <= '0;
            gap_q     <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            sel_q     <= '0;
            en_q      <= EN_ACTIVE_LOW;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            dwell_q   <= dwell_d;
            gap_q     <= gap_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign en_out  = en_q;
    assign sel     = sel_q;
    assign strobe  = strobe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err_cnt = err_cnt_q;
    assign err     = err_q;
endmodule

// File: tb/tb_mux_test_sequencer.sv
// Directed bench for mux_test_sequencer: default build, a 2-bit error counter
// build, and a fast active-low build (DWELL=EN_CYCLES=1, no gap).
module tb_mux_test_sequencer;
    logic clk, rst;
    int   tests, fails, cyc;

    // default instance
    logic       d_en, d_cont, d_y, d_ymode;
    logic [7:0] d_pat;
    logic       d_eno, d_stb, d_busy, d_done, d_err;
    logic [2:0] d_sel;
    logic [7:0] d_cnt;
    // ERR_W=2 instance
    logic       s_en, s_cont;
    logic [7:0] s_pat;
    logic       s_eno, s_stb, s_busy, s_done, s_err;
    logic [2:0] s_sel;
    logic [1:0] s_cnt;
    // fast active-low instance
    logic       f_en, f_cont, f_y;
    logic [7:0] f_pat;
    logic       f_eno, f_stb, f_busy, f_done, f_err;
    logic [2:0] f_sel;
    logic [7:0] f_cnt;

    logic [6:0] obs, exp_v;

    assign d_y = d_ymode ? 1'b0 : d_pat[d_sel];
    assign f_y = f_pat[f_sel];

    mux_test_sequencer u_def (
        .clk(clk), .rst(rst), .enable(d_en), .continuous(d_cont), .pattern(d_pat),
        .dut_y(d_y), .en_out(d_eno), .sel(d_sel), .strobe(d_stb), .busy(d_busy),
        .done(d_done), .err_cnt(d_cnt), .err(d_err));

    mux_test_sequencer #(.ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .enable(s_en), .continuous(s_cont), .pattern(s_pat),
        .dut_y(1'b0), .en_out(s_eno), .sel(s_sel), .strobe(s_stb), .busy(s_busy),
        .done(s_done), .err_cnt(s_cnt), .err(s_err));

    mux_test_sequencer #(.DWELL(1), .EN_CYCLES(1), .GAP_CYCLES(0), .EN_ACTIVE_LOW(1'b1)) u_fast (
        .clk(clk), .rst(rst), .enable(f_en), .continuous(f_cont), .pattern(f_pat),
        .dut_y(f_y), .en_out(f_eno), .sel(f_sel), .strobe(f_stb), .busy(f_busy),
        .done(f_done), .err_cnt(f_cnt), .err(f_err));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic test_reset();
        tests++;
        if ({d_sel, d_eno, d_stb, d_busy, d_done, d_cnt, d_err} !== 16'h0) begin
            fails++; $display("FAIL reset_def got %h want 0", {d_sel, d_eno, d_stb, d_busy, d_done, d_cnt, d_err});
        end
        tests++;
        if ({f_sel, f_eno, f_stb, f_busy, f_done, f_err} !== 8'b000_1_0_0_0_0) begin
            fails++; $display("FAIL reset_fast got %b want 00010000", {f_sel, f_eno, f_stb, f_busy, f_done, f_err});
        end
        tests++;
        if ({s_sel, s_eno, s_busy, s_cnt, s_err} !== 8'h0) begin
            fails++; $display("FAIL reset_sat got %h want 0", {s_sel, s_eno, s_busy, s_cnt, s_err});
        end
    endtask

    task automatic test_sweep();
        d_pat = 8'hA5; d_ymode = 1'b0; d_cont = 1'b0;
        d_en = 1'b1; cyc = 0; tick();
        for (int c = 1; c <= 62; c++) begin
            go_to(c);
            obs = {d_sel, d_eno, d_stb, d_busy, d_done};
            if (c <= 32) exp_v = {3'((c - 1) / 4), ((c - 1) % 4) < 2, ((c - 1) % 4) == 1, 1'b1, 1'b0};
            else if (c <= 60) exp_v = 7'b000_0_0_1_0;
            else if (c == 61) exp_v = 7'b000_0_0_0_1;
            else exp_v = 7'b0;
            tests++;
            if (obs !== exp_v) begin
                fails++; $display("FAIL sweep c=%0d got %b want %b", c, obs, exp_v);
            end
        end
        go_to(75);
        tests++;
        if ({d_busy, d_done, d_cnt, d_err} !== 11'b0) begin
            fails++; $display("FAIL wait_low_clean got %b want 0", {d_busy, d_done, d_cnt, d_err});
        end
        d_en = 1'b0; tick(); tick();
    endtask

    task automatic test_mismatch();
        d_pat = 8'hA5; d_ymode = 1'b1;
        d_en = 1'b1; cyc = 0; tick();
        go_to(3);
        tests++;
        if (d_cnt !== 8'd1 || d_err !== 1'b1) begin
            fails++; $display("FAIL mism_first got cnt=%0d err=%b want 1/1", d_cnt, d_err);
        end
        go_to(61);
        tests++;
        if ({d_done, d_cnt, d_err} !== {1'b1, 8'd4, 1'b1}) begin
            fails++; $display("FAIL mism_done got done=%b cnt=%0d err=%b want 1/4/1", d_done, d_cnt, d_err);
        end
        d_en = 1'b0; tick(); tick();
        tests++;
        if (d_cnt !== 8'd4 || d_err !== 1'b1) begin
            fails++; $display("FAIL mism_hold got cnt=%0d err=%b want 4/1", d_cnt, d_err);
        end
        d_ymode = 1'b0; d_en = 1'b1; cyc = 0; tick();
        tests++;
        if (d_cnt !== 8'd0 || d_err !== 1'b0 || d_busy !== 1'b1) begin
            fails++; $display("FAIL mism_clear got cnt=%0d err=%b busy=%b want 0/0/1", d_cnt, d_err, d_busy);
        end
        d_en = 1'b0; tick(); tick();
    endtask

    task automatic test_abort();
        d_pat = 8'h01; d_ymode = 1'b1;
        d_en = 1'b1; cyc = 0; tick();
        go_to(10);
        tests++;
        if (d_sel !== 3'd2 || d_stb !== 1'b1) begin
            fails++; $display("FAIL abort_pre got sel=%0d stb=%b want 2/1", d_sel, d_stb);
        end
        d_en = 1'b0; tick();
        tests++;
        if ({d_sel, d_eno, d_stb, d_busy, d_done, d_cnt} !== {3'd0, 4'b0, 8'd1}) begin
            fails++; $display("FAIL abort_idle got %b want %b", {d_sel, d_eno, d_stb, d_busy, d_done, d_cnt}, {3'd0, 4'b0, 8'd1});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (d_done !== 1'b0 || d_busy !== 1'b0 || d_cnt !== 8'd1) begin
                fails++; $display("FAIL abort_hold i=%0d got done=%b busy=%b cnt=%0d want 0/0/1", i, d_done, d_busy, d_cnt);
            end
        end
        d_en = 1'b1; tick();
        tests++;
        if (d_cnt !== 8'd0 || d_sel !== 3'd0 || d_eno !== 1'b1) begin
            fails++; $display("FAIL abort_rearm got cnt=%0d sel=%0d en=%b want 0/0/1", d_cnt, d_sel, d_eno);
        end
        d_en = 1'b0; tick(); tick();
    endtask

    task automatic test_reset_midgap();
        d_pat = 8'hA5; d_ymode = 1'b1;
        d_en = 1'b1; cyc = 0; tick();
        go_to(40);
        tests++;
        if ({d_busy, d_sel, d_cnt} !== {1'b1, 3'd0, 8'd4}) begin
            fails++; $display("FAIL gap_pre got busy=%b sel=%0d cnt=%0d want 1/0/4", d_busy, d_sel, d_cnt);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({d_sel, d_eno, d_stb, d_busy, d_done, d_cnt, d_err} !== 16'h0) begin
            fails++; $display("FAIL gap_rst got %h want 0", {d_sel, d_eno, d_stb, d_busy, d_done, d_cnt, d_err});
        end
        #1 rst = 1'b0;
        d_ymode = 1'b0;
        tick();
        tests++;
        if ({d_sel, d_eno, d_stb, d_busy, d_done} !== 7'b000_1_0_1_0) begin
            fails++; $display("FAIL gap_restart got %b want 0001010", {d_sel, d_eno, d_stb, d_busy, d_done});
        end
        d_en = 1'b0; tick(); tick();
    endtask

    task automatic test_continuous();
        s_pat = 8'hFF; s_cont = 1'b1;
        s_en = 1'b1; cyc = 0; tick();
        go_to(3);
        tests++;
        if (s_cnt !== 2'd1 || s_err !== 1'b1) begin
            fails++; $display("FAIL sat_first got cnt=%0d err=%b want 1/1", s_cnt, s_err);
        end
        go_to(11);
        tests++;
        if (s_cnt !== 2'd3) begin
            fails++; $display("FAIL sat_three got %0d want 3", s_cnt);
        end
        go_to(33);
        tests++;
        if ({s_sel, s_eno, s_busy, s_cnt} !== {3'd0, 1'b0, 1'b1, 2'd3}) begin
            fails++; $display("FAIL sat_gap got %b want 00001_11", {s_sel, s_eno, s_busy, s_cnt});
        end
        go_to(60);
        tests++;
        if (s_busy !== 1'b1 || s_eno !== 1'b0) begin
            fails++; $display("FAIL sat_gapend got busy=%b en=%b want 1/0", s_busy, s_eno);
        end
        go_to(61);
        tests++;
        if ({s_sel, s_eno, s_stb, s_busy, s_done, s_cnt} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3}) begin
            fails++; $display("FAIL sat_wrap got %b want 000101011", {s_sel, s_eno, s_stb, s_busy, s_done, s_cnt});
        end
        go_to(62);
        tests++;
        if (s_stb !== 1'b1) begin
            fails++; $display("FAIL sat_stb2 got %b want 1", s_stb);
        end
        go_to(121);
        tests++;
        if ({s_sel, s_eno, s_busy, s_cnt} !== {3'd0, 1'b1, 1'b1, 2'd3}) begin
            fails++; $display("FAIL sat_third got %b want 0001111", {s_sel, s_eno, s_busy, s_cnt});
        end
        go_to(125);
        tests++;
        if (s_sel !== 3'd1 || s_cnt !== 2'd3) begin
            fails++; $display("FAIL sat_late got sel=%0d cnt=%0d want 1/3", s_sel, s_cnt);
        end
        s_en = 1'b0; tick();
    endtask

    task automatic test_back_to_back();
        f_pat = 8'hA5; f_cont = 1'b1;
        f_en = 1'b1; cyc = 0; tick();
        for (int c = 1; c <= 20; c++) begin
            go_to(c);
            tests++;
            if ({f_sel, f_eno, f_stb, f_busy, f_done} !== {3'((c - 1) % 8), 4'b0110}) begin
                fails++; $display("FAIL fast c=%0d got %b want %b", c, {f_sel, f_eno, f_stb, f_busy, f_done}, {3'((c - 1) % 8), 4'b0110});
            end
        end
        tests++;
        if (f_err !== 1'b0 || f_cnt !== 8'd0) begin
            fails++; $display("FAIL fast_err got err=%b cnt=%0d want 0/0", f_err, f_cnt);
        end
        f_cont = 1'b0;
        go_to(25);
        tests++;
        if ({f_sel, f_eno, f_stb, f_busy, f_done} !== 7'b000_1_0_0_1) begin
            fails++; $display("FAIL fast_done got %b want 0001001", {f_sel, f_eno, f_stb, f_busy, f_done});
        end
        go_to(26);
        tests++;
        if ({f_eno, f_busy, f_done} !== 3'b100) begin
            fails++; $display("FAIL fast_wait got %b want 100", {f_eno, f_busy, f_done});
        end
        f_en = 1'b0; tick();
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        clk = 1'b0; rst = 1'b1;
        d_en = 0; d_cont = 0; d_pat = 8'h0; d_ymode = 0;
        s_en = 0; s_cont = 0; s_pat = 8'h0;
        f_en = 0; f_cont = 0; f_pat = 8'h0;
        #12;
        test_reset();
        rst = 1'b0;
        tick();
        test_sweep();
        test_mismatch();
        test_abort();
        test_reset_midgap();
        test_continuous();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux_test_sequencer.md
Name: mux_test_sequencer

Overview:
Parametrised stimulus and check engine for testing external N:1 multiplexer ICs on the bench.
- Steps a select bus through every code and pulses the chip enable in a window of each code's dwell.
- Samples the DUT output once per code and compares it against a per-code expected bit.
- Counts mismatches and supports single-shot or continuous sweeps separated by a programmable gap.

Parameters:
SEL_W, 3, select bus width; 2**SEL_W codes per sweep
DWELL, 4, cycles spent on each select code (>=1)
EN_CYCLES, 2, cycles of enable asserted at start of each dwell (1..DWELL)
GAP_CYCLES, 28, idle cycles after the last code before sweep end (>=0)
EN_ACTIVE_LOW, 0, 1 = en_out asserted low
ERR_W, 8, mismatch counter width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  run request, synchronous, active-high
continuous  input  1  1 = repeat sweeps; sampled on IDLE->SWEEP and at each sweep end
pattern  input  2**SEL_W  expected DUT output per code; bit i for sel==i
dut_y  input  1  DUT output, synchronous to clk
en_out  output  1  DUT enable, polarity per EN_ACTIVE_LOW
sel  output  SEL_W  DUT select code
strobe  output  1  high in the cycle dut_y is checked
busy  output  1  high in SWEEP and GAP
done  output  1  one-cycle pulse at end of single-shot run
err_cnt  output  ERR_W  saturating mismatch count
err  output  1  sticky, set on any mismatch in current run

Behaviour:
- All outputs are registered.
- rst asserted, at any time including mid-sweep: immediately go to IDLE.
  - Reset values: sel=0, en_out inactive (0, or 1 if EN_ACTIVE_LOW), strobe=0, busy=0, done=0, err_cnt=0, err=0.
- States: IDLE, SWEEP, GAP, DONE, WAIT_LOW.
- IDLE: outputs inactive. enable=1 sampled -> SWEEP next cycle, with code=0 and dwell_cnt=0.
  - On this transition, clear err_cnt and err. Latch continuous.
- SWEEP:
  - sel=code.
  - en_out active while dwell_cnt < EN_CYCLES.
  - strobe=1 when dwell_cnt == EN_CYCLES-1.
  - On a strobe cycle, compare dut_y against pattern[code] at the closing edge.
    - Mismatch: err_cnt increments, saturating at all-ones; err=1. Both are visible the next cycle.
  - dwell_cnt == DWELL-1:
    - If code == 2**SEL_W-1: go to GAP, or if GAP_CYCLES == 0 go directly to the sweep-end decision.
    - Otherwise: code+1, dwell_cnt=0.
- GAP: sel=0, en_out inactive, strobe=0, busy=1. Lasts exactly GAP_CYCLES cycles.
- Sweep end:
  - continuous=1: SWEEP with code=0. err_cnt and err are kept and accumulate across sweeps.
  - continuous=0: DONE.
- DONE: done=1 for exactly one cycle, busy=0. Next state is WAIT_LOW.
- WAIT_LOW: outputs inactive. Hold until enable=0, then IDLE. A new run requires an enable 0->1 re-arm.
- enable=0 in any state: IDLE next cycle.
  - sel=0, en_out inactive, busy=0, no done pulse.
  - err_cnt and err are retained until the next run start.
- Sweep period is 2**SEL_W*DWELL + GAP_CYCLES cycles. With defaults, 32+28=60 cycles.
- Counter widths: sized from the parameters. No wrap is permitted inside one dwell or gap.

Test Plan:
1. Defaults, pattern=8'hA5, dut_y=pattern[sel] on strobe, enable rises before edge 0:
   - Cycles 1-32: sel=0..7, each held 4 cycles; en_out high in the first 2 cycles of each; strobe on the 2nd.
   - Cycles 33-60: GAP, sel=0, busy=1.
   - Cycle 61: done=1. Then WAIT_LOW. err_cnt=0, err=0.
2. Same run with dut_y stuck 0 -> err_cnt=4 (the four 1-bits of A5), err=1. err_cnt is cleared at the next run start.
3. continuous=1, ERR_W=2, dut_y stuck 0, pattern=8'hFF:
   - sel returns to 0 every 60 cycles.
   - err_cnt saturates at 3 during the first sweep and never wraps.
4. enable dropped at cycle 10 (sel=2) -> cycle 11: IDLE, sel=0, en_out=0, busy=0, no done. err_cnt is held until enable is reasserted, then cleared.
5. rst pulsed mid-GAP, asynchronous and not edge-aligned -> all outputs take reset values before the next clk edge. Sequencer restarts only from IDLE with enable=1.
6. EN_ACTIVE_LOW=1, GAP_CYCLES=0, DWELL=EN_CYCLES=1, continuous=1:
   - en_out=1 at reset; en_out=0 every SWEEP cycle.
   - strobe every cycle; sel increments every cycle; period is 8 cycles back to back.
